// File: rtl/da2_multi_serializer_if.sv
// da2_multi_serializer_if: request bus and DAC-side lines of the multi-channel DA2 serializer
// Parameter CH sets the number of channels / SDATA lines.
// Signals: update (frame request), value[12*CH] (channel n at [12n+11:12n]),
//          mode[2*CH] (channel n PD1:PD0 at [2n+1:2n]), busy, done (one-cycle end-of-frame pulse),
//          sclk (idles high), sync (active low), sdata[CH] (MSB first).
// Modports: master = board/test logic, slave = the serializer.
interface da2_multi_serializer_if #(parameter int CH = 2);
  logic update;
  logic [12*CH-1:0] value;
  logic [2*CH-1:0] mode;
  logic busy;
  logic done;
  logic sclk;
  logic sync;
  logic [CH-1:0] sdata;
  modport master (output update, value, mode, input busy, done, sclk, sync, sdata);
  modport slave (input update, value, mode, output busy, done, sclk, sync, sdata);
endinterface

// File: rtl/da2_multi_serializer.sv
// da2_multi_serializer: shared SCLK/SYNC, CH parallel SDATA lines to DAC121S101-class DACs
// Ports: clk, rst (async, active-high), bus (da2_multi_serializer_if.slave).
// Optional macro DA2_LOOP_EN adds input loop_i: with loop_i=1 and nothing pending at the end of
// the gap, a new frame restarts from the live value/mode (continuous refresh).
// Each frame sends {2'b00, mode[n], value[n]} MSB first; SDATA changes on SCLK rising edges so
// it is stable across the falling edge where the DAC samples. One extra frame can be queued.
module da2_multi_serializer #(
  parameter int CH = 2,
  parameter int CLK_DIV = 2,
  parameter int GAP_CYC = 2
) (
  input logic clk,
  input logic rst,
`ifdef DA2_LOOP_EN
  input logic loop_i,
`endif
  da2_multi_serializer_if.slave bus
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int GW = GAP_CYC > 1 ? $clog2(GAP_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0] cnt_q, cnt_d;
  logic sclk_q, sclk_d, sync_q, sync_d, busy_q, busy_d, done_q, done_d, pend_q, pend_d;
  logic [CH-1:0][15:0] shift_q, shift_d;
  logic [12*CH-1:0] shv_q, shv_d;
  logic [2*CH-1:0] shm_q, shm_d;
  logic loop, start, use_sh;
`ifdef DA2_LOOP_EN
  assign loop = loop_i;
`else
  assign loop = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      div_q <= '0;
      gap_q <= '0;
      cnt_q <= '0;
      sclk_q <= 1'b1;
      sync_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pend_q <= 1'b0;
      shift_q <= '0;
      shv_q <= '0;
      shm_q <= '0;
    end else begin
      state_q <= state_d;
      div_q <= div_d;
      gap_q <= gap_d;
      cnt_q <= cnt_d;
      sclk_q <= sclk_d;
      sync_q <= sync_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pend_q <= pend_d;
      shift_q <= shift_d;
      shv_q <= shv_d;
      shm_q <= shm_d;
    end
  always_comb begin
    state_d = state_q;
    div_d = div_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    sclk_d = sclk_q;
    sync_d = sync_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pend_d = pend_q;
    shift_d = shift_q;
    shv_d = shv_q;
    shm_d = shm_q;
    start = 1'b0;
    use_sh = 1'b0;
    if (bus.update && state_q != IDLE) begin
      pend_d = 1'b1;
      shv_d = bus.value;
      shm_d = bus.mode;
    end
    case (state_q)
      IDLE: start = bus.update;
      SHIFT: begin
        div_d = div_q + 1'b1;
        if (div_q == DW'(CLK_DIV - 1)) begin
          div_d = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) cnt_d = cnt_q + 5'd1;
          else if (cnt_q == 5'd16) begin
            sync_d = 1'b1;
            shift_d = '0;
            gap_d = '0;
            state_d = GAP;
          end else
            for (int n = 0; n < CH; n++) shift_d[n] = {shift_q[n][14:0], 1'b0};
        end
      end
      GAP: begin
        gap_d = gap_q + 1'b1;
        if (gap_q == GW'(GAP_CYC - 1)) begin
          done_d = 1'b1;
          use_sh = pend_q;
          // an update landing on the final gap edge with nothing queued starts directly from the live inputs
          start = pend_q || bus.update || loop;
          if (!start) begin
            state_d = IDLE;
            busy_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (start) begin
      for (int n = 0; n < CH; n++)
        shift_d[n] = use_sh ? {2'b00, shm_q[2*n +: 2], shv_q[12*n +: 12]}
                            : {2'b00, bus.mode[2*n +: 2], bus.value[12*n +: 12]};
      // consuming the shadow while a new update arrives keeps that update queued
      pend_d = use_sh && bus.update;
      sync_d = 1'b0;
      busy_d = 1'b1;
      div_d = '0;
      cnt_d = '0;
      state_d = SHIFT;
    end
  end
  assign bus.sclk = sclk_q;
  assign bus.sync = sync_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  for (genvar g = 0; g < CH; g++) assign bus.sdata[g] = shift_q[g][15];
endmodule
